// File: rtl/ice_rdarb_pkg.sv
// ice_rdarb_pkg: shared widths and state encoding for the ICE register read arbiter.
package ice_rdarb_pkg;
  localparam int ICE_AW = 32;
  localparam int ICE_DW = 32;
  localparam int CNT_W  = 16;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    ACK  = 2'b10
  } state_e;
endpackage

// File: rtl/ice_rdarb_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; last names the port granted most recently.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | last);
  assign gnt[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/ice_rdarb.sv
// ice_rdarb: round-robin sequencer of host/trace reads onto the ICE register read bus.
module ice_rdarb
  import ice_rdarb_pkg::*;
#(
  parameter int WAIT_CYC = 1
) (
  input  logic              CLK,
  input  logic              RESB,
  input  logic              REQ0,
  input  logic              REQ1,
  input  logic [ICE_AW-1:0] ADDR0,
  input  logic [ICE_AW-1:0] ADDR1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [ICE_DW-1:0] RDATA0,
  output logic [ICE_DW-1:0] RDATA1,
  output logic [ICE_AW-1:0] ICEIFA,
  input  logic [ICE_DW-1:0] ICEDO,
  output logic              BUSY,
  output logic [CNT_W-1:0]  ACCCNT
);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);
  logic [1:0]        state_q, state_d;
  logic              last_q, last_d, win_q, win_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ICE_AW-1:0] ifa_q, ifa_d;
  logic [ICE_DW-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [1:0]        gnt;
  logic              in_addr, in_ack, in_idle, take, done;
  rr_arb2 u_arb (
    .req  ({REQ1, REQ0}),
    .last (last_q),
    .gnt  (gnt)
  );
  // the unused encoding 2'b11 behaves as IDLE
  always_comb begin
    in_addr = state_q == ADDR;
    in_ack  = state_q == ACK;
    in_idle = !in_addr && !in_ack;
    take    = in_idle && |gnt;
    done    = in_addr && cnt_q == 4'd0;
    state_d = take ? ADDR : done ? ACK : in_addr ? ADDR : IDLE;
    last_d  = take ? gnt[1] : last_q;
    win_d   = take ? gnt[1] : win_q;
    cnt_d   = take ? WAIT_LD : (in_addr && !done) ? cnt_q - 4'd1 : cnt_q;
    ifa_d   = take ? (gnt[1] ? ADDR1 : ADDR0) : done ? '0 : ifa_q;
    rd0_d   = (done && !win_q) ? ICEDO : rd0_q;
    rd1_d   = (done && win_q) ? ICEDO : rd1_q;
    ack0_d  = done && !win_q;
    ack1_d  = done && win_q;
    acc_d   = acc_q + CNT_W'(done);
  end
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      cnt_q   <= '0;
      ifa_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ifa_q   <= ifa_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      acc_q   <= acc_d;
    end
  end
  assign ACK0   = ack0_q;
  assign ACK1   = ack1_q;
  assign RDATA0 = rd0_q;
  assign RDATA1 = rd1_q;
  assign ICEIFA = ifa_q;
  assign BUSY   = in_addr || in_ack;
  assign ACCCNT = acc_q;
endmodule

// File: tb/tb_ice_rdarb.sv
// tb_ice_rdarb: scoreboard bench for ice_rdarb with WAIT_CYC=1 and WAIT_CYC=3 instances.
module tb_ice_rdarb;
  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] m_cnt = 0;
  logic CLK = 0;
  logic RESB_a = 0, REQ0_a = 0, REQ1_a = 0, ACK0_a, ACK1_a, BUSY_a;
  logic [31:0] ADDR0_a = 0, ADDR1_a = 0, RDATA0_a, RDATA1_a, ICEIFA_a, ICEDO_a;
  logic [15:0] ACCCNT_a;
  logic RESB_b = 0, REQ0_b = 0, REQ1_b = 0, ACK0_b, ACK1_b, BUSY_b;
  logic [31:0] ADDR0_b = 0, ADDR1_b = 0, RDATA0_b, RDATA1_b, ICEIFA_b, ICEDO_b = 0;
  logic [15:0] ACCCNT_b;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [31:0] mux(input logic [31:0] a);
    if (a == 32'h0880_8000) return 32'h1234_5678;
    if (a == 32'h0880_4008) return 32'h0000_0003;
    if (a == 32'h0880_0010) return 32'hA5A5_0001;
    return a ^ 32'hFFFF_0000;
  endfunction
  assign ICEDO_a = mux(ICEIFA_a);
  ice_rdarb #(.WAIT_CYC(1)) u_a (
    .CLK(CLK), .RESB(RESB_a), .REQ0(REQ0_a), .REQ1(REQ1_a), .ADDR0(ADDR0_a), .ADDR1(ADDR1_a),
    .ACK0(ACK0_a), .ACK1(ACK1_a), .RDATA0(RDATA0_a), .RDATA1(RDATA1_a), .ICEIFA(ICEIFA_a),
    .ICEDO(ICEDO_a), .BUSY(BUSY_a), .ACCCNT(ACCCNT_a)
  );
  ice_rdarb #(.WAIT_CYC(3)) u_b (
    .CLK(CLK), .RESB(RESB_b), .REQ0(REQ0_b), .REQ1(REQ1_b), .ADDR0(ADDR0_b), .ADDR1(ADDR1_b),
    .ACK0(ACK0_b), .ACK1(ACK1_b), .RDATA0(RDATA0_b), .RDATA1(RDATA1_b), .ICEIFA(ICEIFA_b),
    .ICEDO(ICEDO_b), .BUSY(BUSY_b), .ACCCNT(ACCCNT_b)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic push(input logic port, input logic [31:0] addr);
    m_cnt = m_cnt + 16'd1;
    sb.push_back('{port: port, data: mux(addr), cnt: m_cnt});
  endtask
  // monitor: every ACK on DUT a is matched against the oldest expected read
  always @(negedge CLK) begin
    if (ACK0_a || ACK1_a) begin
      exp_t e;
      if (sb.size() == 0) chk("sb_unexpected_ack", {30'd0, ACK1_a, ACK0_a}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_onehot", {30'd0, ACK1_a, ACK0_a}, e.port ? 32'd2 : 32'd1);
        chk(e.port ? "rdata1" : "rdata0", e.port ? RDATA1_a : RDATA0_a, e.data);
        chk("acccnt", {16'd0, ACCCNT_a}, {16'd0, e.cnt});
      end
    end
  end
  task automatic serve(input logic r0, input logic r1, input logic [31:0] a0,
                       input logic [31:0] a1, input int gap);
    int c0 = 0, c1 = 0;
    ADDR0_a = a0;
    ADDR1_a = a1;
    REQ0_a = r0;
    REQ1_a = r1;
    for (int n = 0; n < 40 && (REQ0_a || REQ1_a); n++) begin
      @(negedge CLK);
      if (ACK0_a) begin REQ0_a = 0; c0 = cyc; end
      if (ACK1_a) begin REQ1_a = 0; c1 = cyc; end
    end
    if (REQ0_a || REQ1_a) begin
      chk("serve_timeout", {30'd0, REQ1_a, REQ0_a}, 32'd0);
      REQ0_a = 0;
      REQ1_a = 0;
    end
    if (gap != 0) chk("tie_gap", 32'(c1 - c0), 32'(gap));
    @(negedge CLK);
  endtask
  task automatic reset_a();
    RESB_a = 0;
    repeat (2) @(negedge CLK);
    RESB_a = 1;
    m_cnt = 0;
    @(negedge CLK);
  endtask
  initial begin
    repeat (2) @(negedge CLK);
    RESB_a = 1;
    RESB_b = 1;
    chk("rst_iceifa", ICEIFA_a, 0);
    chk("rst_ack", {30'd0, ACK1_a, ACK0_a}, 0);
    chk("rst_rdata0", RDATA0_a, 0);
    chk("rst_rdata1", RDATA1_a, 0);
    chk("rst_busy", {31'd0, BUSY_a}, 0);
    chk("rst_acccnt", {16'd0, ACCCNT_a}, 0);
    push(0, 32'h0880_8000);
    ADDR0_a = 32'h0880_8000;
    REQ0_a = 1;
    @(negedge CLK);
    chk("single_iceifa", ICEIFA_a, 32'h0880_8000);
    chk("single_busy", {31'd0, BUSY_a}, 1);
    chk("single_noack", {31'd0, ACK0_a}, 0);
    @(negedge CLK);
    chk("single_ack", {31'd0, ACK0_a}, 1);
    chk("single_iceifa_ack", ICEIFA_a, 0);
    REQ0_a = 0;
    @(negedge CLK);
    chk("single_ack_pulse", {31'd0, ACK0_a}, 0);
    chk("single_idle_busy", {31'd0, BUSY_a}, 0);
    reset_a();
    push(0, 32'h0880_0100);
    push(1, 32'h0880_4008);
    serve(1, 1, 32'h0880_0100, 32'h0880_4008, 3);
    push(0, 32'h0880_0200);
    serve(1, 0, 32'h0880_0200, 0, 0);
    push(1, 32'h0880_0300);
    push(0, 32'h0880_0400);
    serve(1, 1, 32'h0880_0400, 32'h0880_0300, -3);
    push(1, 32'h0880_0010);
    ADDR1_a = 32'h0880_0010;
    REQ1_a = 1;
    @(negedge CLK);
    REQ1_a = 0;
    ADDR1_a = 32'h0880_0500;
    @(negedge CLK);
    chk("drop_ack1", {31'd0, ACK1_a}, 1);
    @(negedge CLK);
    push(0, 32'h0880_0600);
    push(0, 32'h0880_0700);
    ADDR0_a = 32'h0880_0600;
    REQ0_a = 1;
    repeat (2) @(negedge CLK);
    chk("hold_first_ack", {31'd0, ACK0_a}, 1);
    ADDR0_a = 32'h0880_0700;
    repeat (3) @(negedge CLK);
    chk("hold_second_ack", {31'd0, ACK0_a}, 1);
    REQ0_a = 0;
    @(negedge CLK);
    force u_a.acc_q = 16'hFFFE;
    @(negedge CLK);
    release u_a.acc_q;
    m_cnt = 16'hFFFE;
    push(0, 32'h0880_0800);
    serve(1, 0, 32'h0880_0800, 0, 0);
    push(1, 32'h0880_0900);
    serve(0, 1, 0, 32'h0880_0900, 0);
    ADDR0_b = 32'h0880_0020;
    REQ0_b = 1;
    @(negedge CLK);
    chk("w3_iceifa_c1", ICEIFA_b, 32'h0880_0020);
    chk("w3_busy_c1", {31'd0, BUSY_b}, 1);
    ICEDO_b = 32'h1111_1111;
    @(negedge CLK);
    chk("w3_iceifa_c2", ICEIFA_b, 32'h0880_0020);
    ICEDO_b = 32'h2222_2222;
    @(negedge CLK);
    chk("w3_iceifa_c3", ICEIFA_b, 32'h0880_0020);
    chk("w3_noack_c3", {31'd0, ACK0_b}, 0);
    ICEDO_b = 32'h3333_3333;
    @(negedge CLK);
    chk("w3_ack_c4", {31'd0, ACK0_b}, 1);
    chk("w3_rdata0", RDATA0_b, 32'h3333_3333);
    chk("w3_iceifa_c4", ICEIFA_b, 0);
    chk("w3_acccnt", {16'd0, ACCCNT_b}, 1);
    REQ0_b = 0;
    @(negedge CLK);
    chk("w3_ack_pulse", {31'd0, ACK0_b}, 0);
    ADDR1_b = 32'h0880_0030;
    REQ1_b = 1;
    repeat (2) @(negedge CLK);
    chk("mid_iceifa_pre", ICEIFA_b, 32'h0880_0030);
    RESB_b = 0;
    REQ1_b = 0;
    #1;
    chk("mid_iceifa", ICEIFA_b, 0);
    chk("mid_rdata0", RDATA0_b, 0);
    chk("mid_acccnt", {16'd0, ACCCNT_b}, 0);
    chk("mid_busy", {31'd0, BUSY_b}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("mid_noack", {30'd0, ACK1_b, ACK0_b}, 0);
    end
    RESB_b = 1;
    @(negedge CLK);
    chk("mid_after_ack", {30'd0, ACK1_b, ACK0_b}, 0);
    chk("mid_rdata1", RDATA1_b, 0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
